serial_adder_ctrl: RTL

Bit-serial add controller that sequences a single one-bit add cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first. Accepts operands through a valid/ready handshake, holds the running carry in a register, and assembles the result in a shift register. Sits between operand producers and result consumers wherever area matters more than throughput.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_fa_cell.sv | 21 ++
 rtl/serial_adder_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add controller.
// State encoding, default width and counter sizing helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder: two half-adder cells and an OR on their carries.
// Purely combinational.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    assign s1   = a ^ b;
    assign c1   = a & b;
    assign s    = s1 ^ cin;
    assign c2   = s1 & cin;
    assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller, LSB first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b mode).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             done,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             bit_s;
    logic             bit_c;

    serial_fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .s    (bit_s),
        .cout (bit_c)
    );

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sh  <= a;
                        cnt   <= '0;
                        state <= RUN;
`ifdef SERIAL_ADDER_SUB_EN
                        // a - b as a + ~b + 1
                        b_sh  <= sub ? ~b : b;
                        c     <= sub;
`else
                        b_sh  <= b;
                        c     <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    acc  <= {bit_s, acc[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= bit_c;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= {bit_s, acc[WIDTH-1:1]};
                        carry <= bit_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
